// File: rtl/mul_pkg.sv
// Shared types and defaults for the repeated-addition multiplier controller.
package mul_pkg;

  localparam int          CW_DEF       = 16;
  localparam logic [15:0] MAX_ITER_DEF = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    CHECK  = 3'd3,
    ACC    = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_e;

  typedef struct packed {
    logic lda;
    logic ldb;
    logic clrp;
    logic ldp;
    logic decb;
    logic busy;
    logic done;
    logic err;
  } ctrl_t;

  // Moore decode: control word presented while sitting in a given state.
  function automatic ctrl_t decode_ctrl(state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      LOAD_A: begin c.lda = 1'b1; c.busy = 1'b1; end
      LOAD_B: begin c.ldb = 1'b1; c.clrp = 1'b1; c.busy = 1'b1; end
      CHECK:  c.busy = 1'b1;
      ACC:    begin c.ldp = 1'b1; c.decb = 1'b1; c.busy = 1'b1; end
      DONE:   c.done = 1'b1;
      ERR:    c.err = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mul_seq_ctrl_if.sv
// Host/datapath-facing bundle of the multiplier sequencer.
interface mul_seq_ctrl_if #(
  parameter int CW = mul_pkg::CW_DEF
);
  logic          start;
  logic          abort;
  logic          eqz;
  logic          lda;
  logic          ldb;
  logic          clrp;
  logic          ldp;
  logic          decb;
  logic          busy;
  logic          done;
  logic          err;
  logic [CW-1:0] iter_cnt;

  modport master (
    output start, abort, eqz,
    input  lda, ldb, clrp, ldp, decb, busy, done, err, iter_cnt
  );

  modport slave (
    input  start, abort, eqz,
    output lda, ldb, clrp, ldp, decb, busy, done, err, iter_cnt
  );
endinterface

// File: rtl/mul_seq_ctrl.sv
// Sequencer for the repeated-addition multiplier: loads A and B, then runs
// CHECK/ACC pairs until the down-counter reaches zero or the iteration limit.
module mul_seq_ctrl
  import mul_pkg::*;
#(
  parameter int          CW       = CW_DEF,
  parameter logic [CW-1:0] MAX_ITER = CW'(MAX_ITER_DEF)
) (
  input logic            clk,
  input logic            rst,
  mul_seq_ctrl_if.slave  bus
);

  state_e        state_q, state_d;
  logic [CW-1:0] iter_q, iter_d;
  ctrl_t         ctrl_q, ctrl_d;

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    case (state_q)
      IDLE:   if (bus.start) state_d = LOAD_A;
      LOAD_A: begin
        state_d = LOAD_B;
        iter_d  = '0;
      end
      LOAD_B: state_d = CHECK;
      CHECK: begin
        // Zero test comes first so B == MAX_ITER still completes normally.
        if (bus.eqz) begin
          state_d = DONE;
        end else if (iter_q == MAX_ITER) begin
          state_d = ERR;
        end else begin
          state_d = ACC;
          iter_d  = iter_q + 1'b1;
        end
      end
      ACC:    state_d = CHECK;
      DONE:   if (!bus.start) state_d = IDLE;
      ERR:    if (!bus.start) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (bus.abort && (state_q inside {LOAD_A, LOAD_B, CHECK, ACC})) begin
      state_d = IDLE;
      iter_d  = iter_q;
    end

    // Outputs are registered from the next state, so they track state_q exactly.
    ctrl_d = decode_ctrl(state_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      iter_q  <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign bus.lda      = ctrl_q.lda;
  assign bus.ldb      = ctrl_q.ldb;
  assign bus.clrp     = ctrl_q.clrp;
  assign bus.ldp      = ctrl_q.ldp;
  assign bus.decb     = ctrl_q.decb;
  assign bus.busy     = ctrl_q.busy;
  assign bus.done     = ctrl_q.done;
  assign bus.err      = ctrl_q.err;
  assign bus.iter_cnt = iter_q;

endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- FSM controller for the repeated-addition multiplier datapath: P = A × B.
- Sequences the 16-bit loadable down-counter (ldb/decb), the A register (lda) and the product accumulator (ldp/clrp).
- Samples the counter's zero flag (eqz = bout==0) supplied by the datapath comparator.
- Provides a start/done handshake to the host, an abort input, an iteration count readout and an iteration-limit error.

Parameters:
- CW, 16, width of iteration counter iter_cnt; matches the down-counter width.
- MAX_ITER, 16'hFFFF, iteration limit; reaching it with eqz=0 forces the ERR state.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset.
- start  in  1  level request; sampled only in IDLE, DONE and ERR.
- abort  in  1  cancel an in-flight operation.
- eqz  in  1  datapath flag, counter output == 0; valid the cycle after any ldb/decb edge.
- lda  out  1  load A register from shared din bus.
- ldb  out  1  load down-counter from din.
- clrp  out  1  clear product accumulator.
- ldp  out  1  accumulator <= accumulator + A.
- decb  out  1  decrement down-counter.
- busy  out  1  operation in progress.
- done  out  1  product valid.
- err  out  1  iteration limit hit.
- iter_cnt  out  CW  accumulate cycles performed in the current or last operation.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: state=IDLE, iter_cnt=0. All outputs 0 in the cycle after rst is sampled high. rst has priority over everything, including mid-operation.
- Control outputs are Moore-decoded from the state register. No output depends combinationally on start, abort or eqz.
- States and transitions:
  - IDLE: all outputs 0. If start=1, go to LOAD_A.
  - LOAD_A: lda=1, busy=1. Host drives A on din this cycle. Next state is LOAD_B.
  - LOAD_B: ldb=1, clrp=1, busy=1, iter_cnt<=0. Host drives B on din this cycle. Next state is CHECK.
  - CHECK: busy=1, no controls asserted; bout is now settled.
    - eqz=1: go to DONE.
    - else if iter_cnt==MAX_ITER: go to ERR.
    - else: go to ACC.
  - ACC: ldp=1, decb=1, busy=1, iter_cnt<=iter_cnt+1. Next state is CHECK. Each iteration therefore takes 2 cycles.
  - DONE: done=1, busy=0. Go to IDLE when start=0; stay while start=1. No auto-restart on a held start.
  - ERR: err=1, busy=0. Go to IDLE when start=0.
- abort=1 in LOAD_A, LOAD_B, CHECK or ACC: next state is IDLE, and no lda/ldb/ldp/decb pulse is issued that edge. iter_cnt holds its value. abort is ignored in IDLE, DONE and ERR.
- Priority: rst > abort > normal transition.
- Latency with start rising in IDLE at cycle 0:
  - LOAD_A at cycle 1, LOAD_B at 2, first CHECK at 3.
  - done first high at cycle 4+2B. B=0 gives cycle 4.
- iter_cnt:
  - Holds its value in IDLE, DONE and ERR for host readout.
  - Never exceeds MAX_ITER; the ERR check precludes any further increment.
- Boundary cases:
  - B=0: no ldp/decb pulse at all; product stays 0 from clrp.
  - B=MAX_ITER: exactly MAX_ITER accumulates occur, then CHECK sees eqz=1 and goes to DONE. The eqz check precedes the limit check.
  - The counter never wraps, because decb is only issued when eqz=0 was seen.

Decomposition:
- Shared package mul_pkg holds:
  - the state enum (IDLE, LOAD_A, LOAD_B, CHECK, ACC, DONE, ERR), with a 3-bit binary encoding;
  - the default CW and MAX_ITER constants.
- No sub-module is required. The iteration counter is inline.
- A top-level mul_top that wires this block to the A register, the down-counter, the accumulator and the zero comparator is a separate block.

Test Plan:
- Reset: hold rst 2 cycles mid-ACC with B=5 -> next cycle state IDLE; all outputs 0; iter_cnt=0; no further decb.
- Normal: A=7, B=3, start held -> lda at cycle 1, ldb+clrp at cycle 2; ldp/decb pulses at cycles 4, 6, 8; done at cycle 10; product 21; iter_cnt=3; done holds until start=0, then IDLE.
- Zero multiplier: B=0 -> no ldp/decb; done at cycle 4; product 0; iter_cnt=0.
- Abort: A=4, B=10, abort pulsed during 3rd ACC -> IDLE next cycle; busy=0; done=0; iter_cnt=3; a fresh start then completes correctly.
- Limit: MAX_ITER=4, B=9 -> 4 accumulates, then err=1 at cycle 12, done never asserted; start low -> IDLE.
- Held start: start kept high through DONE for 5 cycles -> stays in DONE, no second lda; start low then high -> new operation begins.
